// File: rtl/eval_best_select_pkg.sv
// Shared FSM encodings and helpers for the best-move selector.
// Encodings are kept as plain constants so legacy code comparing raw state values still matches.
package eval_best_select_pkg;

   localparam int unsigned STATE_WIDTH = 3;

   localparam logic [STATE_WIDTH-1:0] ST_IDLE      = 3'd0;
   localparam logic [STATE_WIDTH-1:0] ST_ISSUE     = 3'd1;
   localparam logic [STATE_WIDTH-1:0] ST_WAIT_EVAL = 3'd2;
   localparam logic [STATE_WIDTH-1:0] ST_CLEAR     = 3'd3;
   localparam logic [STATE_WIDTH-1:0] ST_WAIT_DROP = 3'd4;
   localparam logic [STATE_WIDTH-1:0] ST_DONE      = 3'd5;

   // IDLE and DONE are the only states in which a new run may be accepted.
   function automatic logic is_busy_state(input logic [STATE_WIDTH-1:0] st);
      return !((st == ST_IDLE) || (st == ST_DONE));
   endfunction

endpackage

// File: rtl/eval_best_select.sv
// Walks a move list through the board evaluator and keeps the best score:
// maximum for white to move, minimum for black, first index wins ties.
module eval_best_select
   import eval_best_select_pkg::*;
#(
   parameter int EVAL_WIDTH  = 32,
   parameter int INDEX_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [INDEX_WIDTH-1:0]        move_count,
   input  logic                          white_to_move,
   output logic                          board_req,
   output logic [INDEX_WIDTH-1:0]        board_index,
   input  logic                          eval_valid,
   input  logic signed [EVAL_WIDTH-1:0]  eval,
   input  logic                          insufficient_material,
   output logic                          clear_eval,
   output logic signed [EVAL_WIDTH-1:0]  best_eval,
   output logic [INDEX_WIDTH-1:0]        best_index,
   output logic                          no_moves,
   output logic                          result_valid,
   output logic                          busy
);

   // Seeds: any real score beats these under the strict compare, except an equal sentinel.
   localparam logic signed [EVAL_WIDTH-1:0] MOST_NEG = {1'b1, {(EVAL_WIDTH-1){1'b0}}};
   localparam logic signed [EVAL_WIDTH-1:0] MOST_POS = {1'b0, {(EVAL_WIDTH-1){1'b1}}};
   localparam logic [INDEX_WIDTH-1:0]       IDX_ONE  = INDEX_WIDTH'(1);

   logic [STATE_WIDTH-1:0]        state;
   logic [INDEX_WIDTH-1:0]        count_q;
   logic                          white_q;
   logic signed [EVAL_WIDTH-1:0]  score_q;
   logic                          replace_best;
   logic                          last_board;

   function automatic logic better(input logic                         white,
                                   input logic signed [EVAL_WIDTH-1:0] cand,
                                   input logic signed [EVAL_WIDTH-1:0] cur);
      return white ? (cand > cur) : (cand < cur);
   endfunction

   assign replace_best = better(white_q, score_q, best_eval);
   assign last_board   = (board_index == (count_q - IDX_ONE));

   assign board_req  = (state == ST_ISSUE);
   assign clear_eval = (state == ST_CLEAR);
   assign busy       = is_busy_state(state);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         count_q      <= '0;
         white_q      <= 1'b0;
         board_index  <= '0;
         score_q      <= '0;
         best_eval    <= '0;
         best_index   <= '0;
         no_moves     <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  count_q     <= move_count;
                  white_q     <= white_to_move;
                  board_index <= '0;
                  best_index  <= '0;
                  if (move_count == '0) begin
                     best_eval    <= '0;
                     no_moves     <= 1'b1;
                     result_valid <= 1'b1;
                     state        <= ST_DONE;
                  end else begin
                     best_eval    <= white_to_move ? MOST_NEG : MOST_POS;
                     no_moves     <= 1'b0;
                     result_valid <= 1'b0;
                     state        <= ST_ISSUE;
                  end
               end
            end

            ST_ISSUE: state <= ST_WAIT_EVAL;

            ST_WAIT_EVAL: begin
               if (eval_valid) begin
                  score_q <= insufficient_material ? '0 : eval;
                  state   <= ST_CLEAR;
               end
            end

            ST_CLEAR: begin
               if (replace_best) begin
                  best_eval  <= score_q;
                  best_index <= board_index;
               end
               state <= ST_WAIT_DROP;
            end

            // Holding here until valid falls keeps one evaluator result from being captured twice.
            ST_WAIT_DROP: begin
               if (!eval_valid) begin
                  if (last_board) begin
                     result_valid <= 1'b1;
                     state        <= ST_DONE;
                  end else begin
                     board_index <= board_index + IDX_ONE;
                     state       <= ST_ISSUE;
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
